reorder_buffer: RTL and testbench

- Circular reorder buffer between issue/rename and the register file.
- Issue allocates one entry per instruction in program order and receives the entry number as the rename tag.
- Execution units (ADD1-3, MUL1-2, LS) write results back by tag over the common data bus (CDB).
- Entries retire strictly in order through the commit bus (commit_idx/commit_data/commit_wen) into the register file.

---
 rtl/reorder_buffer_if.sv | 43 ++++
 rtl/reorder_buffer.sv | 115 +++++++++++
 tb/tb_reorder_buffer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: issue, CDB writeback, commit and occupancy signals of the reorder buffer (ROB_BYPASS_EN adds operand lookup)
interface reorder_buffer_if #(
  parameter int TAG_W = 3,
  parameter int NCDB  = 6
);
  logic                 flush;
  logic                 alloc_valid;
  logic [4:0]           alloc_rd;
  logic                 alloc_is_store;
  logic                 alloc_ready;
  logic [TAG_W-1:0]     alloc_tag;
  logic [NCDB-1:0]      cdb_valid;
  logic [NCDB*TAG_W-1:0] cdb_tag;
  logic [NCDB*32-1:0]   cdb_data;
  logic                 commit_wen;
  logic [4:0]           commit_idx;
  logic [31:0]          commit_data;
  logic                 commit_store;
  logic [TAG_W-1:0]     commit_tag;
  logic [TAG_W:0]       count;
`ifdef ROB_BYPASS_EN
  logic [TAG_W-1:0]     q_tag_j;
  logic [TAG_W-1:0]     q_tag_k;
  logic                 q_hit_j;
  logic                 q_hit_k;
  logic [31:0]          q_val_j;
  logic [31:0]          q_val_k;
`endif
  modport master (
    output flush, alloc_valid, alloc_rd, alloc_is_store, cdb_valid, cdb_tag, cdb_data,
    input  alloc_ready, alloc_tag, commit_wen, commit_idx, commit_data, commit_store, commit_tag, count
`ifdef ROB_BYPASS_EN
    , output q_tag_j, q_tag_k, input q_hit_j, q_hit_k, q_val_j, q_val_k
`endif
  );
  modport slave (
    input  flush, alloc_valid, alloc_rd, alloc_is_store, cdb_valid, cdb_tag, cdb_data,
    output alloc_ready, alloc_tag, commit_wen, commit_idx, commit_data, commit_store, commit_tag, count
`ifdef ROB_BYPASS_EN
    , input q_tag_j, q_tag_k, output q_hit_j, q_hit_k, q_val_j, q_val_k
`endif
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer fed by issue and CDB writeback; ROB_BYPASS_EN adds combinational operand lookup
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3,
  parameter int NCDB  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  reorder_buffer_if.slave  bus
);
  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);
  logic [DEPTH-1:0] busy, done, st, wr_hit;
  logic [4:0]       rd [DEPTH];
  logic [31:0]      val [DEPTH];
  logic [31:0]      wr_val [DEPTH];
  logic [TAG_W-1:0] head, tail, c_tag;
  logic [TAG_W:0]   cnt;
  logic             do_alloc, do_commit, c_wen, c_store;
  logic [4:0]       c_idx;
  logic [31:0]      c_data;
  assign do_alloc         = bus.alloc_valid && (cnt != FULL);
  assign do_commit        = busy[head] && done[head];
  assign bus.alloc_ready  = cnt != FULL;
  assign bus.alloc_tag    = tail;
  assign bus.count        = cnt;
  assign bus.commit_wen   = c_wen;
  assign bus.commit_store = c_store;
  assign bus.commit_idx   = c_idx;
  assign bus.commit_data  = c_data;
  assign bus.commit_tag   = c_tag;
  // per-entry CDB capture: lowest port wins, only into busy-not-done entries not being reallocated
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wr_hit[e] = 1'b0;
      wr_val[e] = '0;
      for (int i = NCDB - 1; i >= 0; i--)
        if (bus.cdb_valid[i] && bus.cdb_tag[i*TAG_W +: TAG_W] == TAG_W'(e)) begin
          wr_hit[e] = 1'b1;
          wr_val[e] = bus.cdb_data[i*32 +: 32];
        end
      wr_hit[e] = wr_hit[e] && busy[e] && !done[e] && !(do_alloc && tail == TAG_W'(e));
    end
  end
  // control state: entry flags, pointers, occupancy and registered commit bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      done    <= '0;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      c_wen   <= 1'b0;
      c_store <= 1'b0;
      c_idx   <= '0;
      c_data  <= '0;
      c_tag   <= '0;
    end else if (bus.flush) begin
      busy    <= '0;
      done    <= '0;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      c_wen   <= 1'b0;
      c_store <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (do_alloc && tail == TAG_W'(e)) begin
          busy[e] <= 1'b1;
          done[e] <= 1'b0;
        end else if (do_commit && head == TAG_W'(e)) begin
          busy[e] <= 1'b0;
          done[e] <= 1'b0;
        end else if (wr_hit[e]) begin
          done[e] <= 1'b1;
        end
      end
      if (do_alloc) tail <= tail + 1'b1;
      if (do_commit) begin
        head   <= head + 1'b1;
        c_tag  <= head;
        c_idx  <= rd[head];
        c_data <= val[head];
      end
      c_wen   <= do_commit && !st[head] && rd[head] != 5'd0;
      c_store <= do_commit && st[head];
      cnt     <= cnt + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
    end
  end
  // entry payload: destination/store flag at allocation, result value at writeback
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (!bus.flush && do_alloc && tail == TAG_W'(e)) begin
        rd[e] <= bus.alloc_rd;
        st[e] <= bus.alloc_is_store;
      end
      if (!bus.flush && wr_hit[e]) val[e] <= wr_val[e];
    end
  end
`ifdef ROB_BYPASS_EN
  function automatic logic [32:0] lookup(input logic [TAG_W-1:0] t);
    logic [32:0] r;
    r = '0;
    for (int i = NCDB - 1; i >= 0; i--)
      if (bus.cdb_valid[i] && bus.cdb_tag[i*TAG_W +: TAG_W] == t && busy[t]) r = {1'b1, bus.cdb_data[i*32 +: 32]};
    if (busy[t] && done[t]) r = {1'b1, val[t]};
    return r;
  endfunction
  // operand forwarding from completed entries or this cycle's CDB traffic
  always_comb begin
    {bus.q_hit_j, bus.q_val_j} = lookup(bus.q_tag_j);
    {bus.q_hit_k, bus.q_val_k} = lookup(bus.q_tag_k);
  end
`else
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and random stimulus against an in-order queue model with a commit scoreboard
module tb_reorder_buffer;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;
  localparam int NCDB  = 6;
  typedef struct {int tag; int rd; bit st; bit done; logic [31:0] val;} ent_t;
  typedef struct {int tag; int rd; logic [31:0] data; bit wen; bit st;} cm_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  ent_t q[$];
  cm_t exp_q[$];
  int mtail = 0;
  bit s_fl = 1'b0, s_av = 1'b0, s_st = 1'b0;
  logic [4:0] s_rd = '0;
  logic [NCDB-1:0] s_cv = '0;
  logic [TAG_W-1:0] s_ct [NCDB];
  logic [31:0] s_cd [NCDB];
  reorder_buffer_if #(.TAG_W(TAG_W), .NCDB(NCDB)) bus ();
  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NCDB(NCDB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic void chk(string n, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction
  // model of one clock edge: commit decided from the old head, then writeback, retire, allocate
  task automatic model_step();
    bit cm;
    int old_n;
    if (s_fl) begin
      q.delete();
      mtail = 0;
      return;
    end
    old_n = q.size();
    cm = old_n > 0 && q[0].done;
    for (int i = 0; i < NCDB; i++)
      if (s_cv[i])
        for (int j = 0; j < q.size(); j++)
          if (q[j].tag == int'(s_ct[i]) && !q[j].done) begin
            q[j].done = 1'b1;
            q[j].val = s_cd[i];
          end
    if (cm) begin
      if (q[0].st || q[0].rd != 0)
        exp_q.push_back('{q[0].tag, q[0].rd, q[0].val, !q[0].st && q[0].rd != 0, q[0].st});
      void'(q.pop_front());
    end
    if (s_av && old_n < DEPTH) begin
      q.push_back('{mtail, int'(s_rd), s_st, 1'b0, 32'h0});
      mtail = (mtail + 1) % DEPTH;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    bus.flush = s_fl;
    bus.alloc_valid = s_av;
    bus.alloc_rd = s_rd;
    bus.alloc_is_store = s_st;
    bus.cdb_valid = s_cv;
    for (int i = 0; i < NCDB; i++) begin
      bus.cdb_tag[i*TAG_W +: TAG_W] = s_ct[i];
      bus.cdb_data[i*32 +: 32] = s_cd[i];
    end
    model_step();
    s_fl = 1'b0;
    s_av = 1'b0;
    s_st = 1'b0;
    s_rd = '0;
    s_cv = '0;
  endtask
  task automatic idle(int n);
    repeat (n) tick();
  endtask
  task automatic alloc(int r, bit st);
    s_av = 1'b1;
    s_rd = 5'(r);
    s_st = st;
  endtask
  task automatic cdb(int p, int t, logic [31:0] d);
    s_cv[p] = 1'b1;
    s_ct[p] = TAG_W'(t);
    s_cd[p] = d;
  endtask
  task automatic do_reset();
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    mtail = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  // monitor: occupancy and tag every cycle, commit pulses against the scoreboard
  initial begin
    cm_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("count", bus.count, q.size());
        chk("alloc_ready", bus.alloc_ready, q.size() != DEPTH);
        chk("alloc_tag", bus.alloc_tag, mtail);
        if (bus.commit_wen || bus.commit_store) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: got tag %0d wen %0b store %0b expected no commit", bus.commit_tag, bus.commit_wen, bus.commit_store);
          end else begin
            e = exp_q.pop_front();
            chk("commit_tag", bus.commit_tag, e.tag);
            chk("commit_wen", bus.commit_wen, e.wen);
            chk("commit_store", bus.commit_store, e.st);
            if (e.wen) begin
              chk("commit_idx", bus.commit_idx, e.rd);
              chk("commit_data", bus.commit_data, e.data);
            end
          end
        end
      end
    end
  end
  initial begin
    int t0, p, budget;
    for (int i = 0; i < NCDB; i++) begin
      s_ct[i] = '0;
      s_cd[i] = '0;
    end
    bus.flush = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_rd = '0;
    bus.alloc_is_store = 1'b0;
    bus.cdb_valid = '0;
    bus.cdb_tag = '0;
    bus.cdb_data = '0;
`ifdef ROB_BYPASS_EN
    bus.q_tag_j = '0;
    bus.q_tag_k = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", bus.count, 0);
    chk("reset_alloc_ready", bus.alloc_ready, 1);
    chk("reset_alloc_tag", bus.alloc_tag, 0);
    chk("reset_commit_wen", bus.commit_wen, 0);
    chk("reset_commit_store", bus.commit_store, 0);
    chk("reset_commit_idx", bus.commit_idx, 0);
    chk("reset_commit_data", bus.commit_data, 0);
    chk("reset_commit_tag", bus.commit_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    alloc(5, 0); tick();
    cdb(0, 0, 32'h12345678); tick();
    idle(3);
    alloc(1, 0); tick();
    alloc(2, 0); tick();
    alloc(3, 0); tick();
    cdb(0, 2, 32'h2222); tick();
    cdb(2, 1, 32'h1111); tick();
    cdb(5, 0, 32'h0); tick();
    idle(4);
    for (int k = 0; k < 8; k++) begin
      alloc(k + 1, 0); tick();
    end
    alloc(20, 0); tick();
    cdb(0, mtail, 32'hCAFE0000); tick();
    idle(2);
    t0 = mtail;
    for (int k = 0; k < NCDB; k++) cdb(k, (t0 + 1 + k) % DEPTH, $urandom);
    tick();
    cdb(0, (t0 + 7) % DEPTH, $urandom); tick();
    idle(3);
    t0 = mtail;
    alloc(7, 1); tick();
    alloc(0, 0); tick();
    cdb(0, t0, 32'h5); cdb(1, (t0 + 1) % DEPTH, 32'h6); tick();
    idle(3);
    s_fl = 1'b1; tick();
    for (int k = 0; k < 4; k++) begin
      alloc(k + 10, 0); tick();
    end
    cdb(1, 3, 32'hA); cdb(4, 3, 32'hB); tick();
    cdb(0, 0, 32'h10); cdb(1, 1, 32'h11); cdb(2, 2, 32'h12); tick();
    idle(4);
    for (int k = 0; k < 3; k++) begin
      alloc(k + 4, 0); tick();
    end
    s_fl = 1'b1; alloc(4, 0); cdb(0, 4, 32'h55); tick();
    cdb(0, 5, 32'h66); tick();
    alloc(8, 0); tick();
    alloc(9, 0); tick();
    idle(2);
    cdb(0, 0, 32'h77); cdb(1, 1, 32'h88); tick();
    idle(3);
    alloc(12, 0); tick();
    alloc(13, 0); tick();
    cdb(0, mtail - 2, 32'h99); tick();
    do_reset();
    idle(2);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 70) alloc($urandom_range(0, 31), $urandom_range(0, 4) == 0);
      for (int k = 0; k < NCDB; k++)
        if ($urandom_range(0, 9) < 3) begin
          if (q.size() > 0 && $urandom_range(0, 3) != 0) cdb(k, q[$urandom_range(0, q.size() - 1)].tag, $urandom);
          else cdb(k, $urandom_range(0, DEPTH - 1), $urandom);
        end
      if ($urandom_range(0, 199) == 0) s_fl = 1'b1;
      tick();
    end
    budget = 0;
    while (q.size() > 0 && budget < 200) begin
      p = 0;
      for (int j = 0; j < q.size(); j++)
        if (!q[j].done && p < NCDB) begin
          cdb(p, q[j].tag, $urandom);
          p++;
        end
      tick();
      budget++;
    end
    chk("drain_left", q.size(), 0);
    idle(3);
    chk("pending_commits", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
